program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 123 ++++++++++++
 tb/tb_program_loader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Loads a RAM image one byte at a time from a valid/ready byte source.
// It can zero-fill the addresses above the last loaded byte and stalls the CPU for the whole session.
module program_loader (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [3:0] i_last_addr,
    input  logic       i_fill_en,
    input  logic       i_abort,
    input  logic [7:0] i_data_in,
    input  logic       i_data_valid,
    output logic       o_data_ready,
    output logic [7:0] o_ram_prog_data,
    output logic [3:0] o_addr_out,
    output logic       o_ram_prog_n,
    output logic       o_wr_prog,
    output logic       o_cpu_hold,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_FILL,
        S_FINISH
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_count;
    logic [3:0] w_next_count;
    logic [7:0] r_data;
    logic [7:0] w_next_data;
    logic [3:0] r_last;
    logic [3:0] w_next_last;
    logic       r_fill;
    logic       w_next_fill;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
            r_data  <= 8'h00;
            r_last  <= 4'd0;
            r_fill  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            r_data  <= w_next_data;
            r_last  <= w_next_last;
            r_fill  <= w_next_fill;
        end
    end

    // Session parameters are only captured on the IDLE->LOAD transition, so later changes are ignored.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_next_data  = r_data;
        w_next_last  = r_last;
        w_next_fill  = r_fill;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_LOAD;
                    w_next_count = 4'd0;
                    w_next_last  = i_last_addr;
                    w_next_fill  = i_fill_en;
                end
            end
            S_LOAD: begin
                if (i_abort) begin
                    w_next_state = S_IDLE;
                end else if (i_data_valid) begin
                    w_next_data  = i_data_in;
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (i_abort) begin
                    w_next_state = S_IDLE;
                end else if (r_count < r_last) begin
                    w_next_count = r_count + 4'd1;
                    w_next_state = S_LOAD;
                end else if (r_fill && (r_count != 4'hF)) begin
                    w_next_count = r_count + 4'd1;
                    w_next_data  = 8'h00;
                    w_next_state = S_FILL;
                end else begin
                    w_next_state = S_FINISH;
                end
            end
            S_FILL: begin
                // The counter parks at 15 rather than wrapping back to address 0.
                if (i_abort) begin
                    w_next_state = S_IDLE;
                end else if (r_count == 4'hF) begin
                    w_next_state = S_FINISH;
                end else begin
                    w_next_count = r_count + 4'd1;
                end
            end
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign o_data_ready    = (r_state == S_LOAD);
    assign o_wr_prog       = (r_state == S_WRITE) || (r_state == S_FILL);
    assign o_done          = (r_state == S_FINISH);
    assign o_busy          = (r_state != S_IDLE);
    assign o_cpu_hold      = o_busy;
    assign o_ram_prog_n    = ~o_busy;
    assign o_addr_out      = r_count;
    assign o_ram_prog_data = r_data;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a scoreboard of expected RAM writes is checked by a write monitor,
// and a bench-side RAM image is built from the observed writes.
module tb_program_loader;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [3:0] i_last_addr;
    logic       i_fill_en;
    logic       i_abort;
    logic [7:0] i_data_in;
    logic       i_data_valid;
    logic       o_data_ready;
    logic [7:0] o_ram_prog_data;
    logic [3:0] o_addr_out;
    logic       o_ram_prog_n;
    logic       o_wr_prog;
    logic       o_cpu_hold;
    logic       o_busy;
    logic       o_done;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        expQ[$];
    int         writeCycles[$];
    int         cycleCount = 0;
    int         doneTotal = 0;
    int         nCompared = 0;
    int         nMismatched = 0;
    int         lastWcBase = 0;
    logic [7:0] ramModel [16] = '{default: 8'h55};
    logic [7:0] expImage [16] = '{default: 8'h55};
    logic [7:0] sessBytes [16];
    int         sessGaps [16];

    program_loader dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_last_addr    (i_last_addr),
        .i_fill_en      (i_fill_en),
        .i_abort        (i_abort),
        .i_data_in      (i_data_in),
        .i_data_valid   (i_data_valid),
        .o_data_ready   (o_data_ready),
        .o_ram_prog_data(o_ram_prog_data),
        .o_addr_out     (o_addr_out),
        .o_ram_prog_n   (o_ram_prog_n),
        .o_wr_prog      (o_wr_prog),
        .o_cpu_hold     (o_cpu_hold),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Every observed RAM write must match the oldest outstanding expected write.
    always @(negedge i_clk) begin
        if (!i_rst && o_wr_prog) begin
            wr_t e;
            writeCycles.push_back(cycleCount);
            if (expQ.size() == 0) begin
                checkOutput("spurious_write_addr", 32'(o_addr_out), 32'hFFFF);
            end else begin
                e = expQ.pop_front();
                checkOutput("wr_addr", 32'(o_addr_out), 32'(e.addr));
                checkOutput("wr_data", 32'(o_ram_prog_data), 32'(e.data));
            end
            ramModel[o_addr_out] = o_ram_prog_data;
        end
        if (!i_rst && o_done) doneTotal++;
    end

    task automatic checkResetOutputs();
        checkOutput("rst_data_ready", 32'(o_data_ready), 32'd0);
        checkOutput("rst_prog_data", 32'(o_ram_prog_data), 32'h00);
        checkOutput("rst_addr", 32'(o_addr_out), 32'd0);
        checkOutput("rst_ram_prog_n", 32'(o_ram_prog_n), 32'd1);
        checkOutput("rst_wr_prog", 32'(o_wr_prog), 32'd0);
        checkOutput("rst_cpu_hold", 32'(o_cpu_hold), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_done", 32'(o_done), 32'd0);
    endtask

    task automatic checkImage();
        for (int a = 0; a < 16; a++) begin
            checkOutput($sformatf("ram_image_%0d", a), 32'(ramModel[a]), 32'(expImage[a]));
        end
    endtask

    task automatic sendByte(input int b, input bit poke);
        bit got = 0;
        for (int k = 0; k < sessGaps[b]; k++) begin
            i_data_valid = 1'b0;
            @(negedge i_clk);
            if (b == 0 || k >= 1) checkOutput("gap_ready", 32'(o_data_ready), 32'd1);
            @(posedge i_clk);
            #1;
        end
        i_data_valid = 1'b1;
        i_data_in    = sessBytes[b];
        if (poke) begin
            i_start     = 1'b1;
            i_last_addr = 4'd0;
            i_fill_en   = 1'b0;
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge i_clk);
            if (o_data_ready === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (!got) checkOutput("ready_timeout", 32'd0, 32'd1);
        @(posedge i_clk);
        #1;
        i_data_valid = 1'b0;
        i_start      = 1'b0;
    endtask

    task automatic applyStimulus(input int last, input bit fill, input int abortAt, input bit poke);
        int  startCycle;
        int  doneBase;
        bit  got;
        for (int a = 0; a <= last; a++) begin
            expQ.push_back({4'(a), sessBytes[a]});
            expImage[a] = sessBytes[a];
        end
        if (fill && last != 15) begin
            for (int a = last + 1; a < 16; a++) begin
                if (abortAt < 0 || a <= abortAt) begin
                    expQ.push_back({4'(a), 8'h00});
                    expImage[a] = 8'h00;
                end
            end
        end
        lastWcBase = writeCycles.size();
        doneBase   = doneTotal;

        @(posedge i_clk);
        #1;
        i_start      = 1'b1;
        i_last_addr  = 4'(last);
        i_fill_en    = fill;
        i_data_valid = (sessGaps[0] == 0);
        i_data_in    = sessBytes[0];
        startCycle   = cycleCount;
        @(posedge i_clk);
        #1;
        i_start     = 1'b0;
        i_last_addr = ~4'(last);
        i_fill_en   = ~fill;

        for (int b = 0; b <= last; b++) sendByte(b, poke && (b == 3));

        if (sessGaps[0] == 0) begin
            if (writeCycles.size() > lastWcBase)
                checkOutput("start_latency", 32'(writeCycles[lastWcBase] - startCycle), 32'd2);
            else
                checkOutput("start_latency_nowrite", 32'd0, 32'd1);
        end

        got = 0;
        if (abortAt >= 0) begin
            for (int t = 0; t < 60; t++) begin
                @(negedge i_clk);
                if (o_wr_prog === 1'b1 && o_addr_out === 4'(abortAt)) begin
                    got = 1;
                    break;
                end
            end
            if (!got) checkOutput("abort_point_timeout", 32'd0, 32'd1);
            i_abort = 1'b1;
            @(posedge i_clk);
            #1;
            i_abort = 1'b0;
            checkOutput("abort_wr_prog", 32'(o_wr_prog), 32'd0);
            checkOutput("abort_ram_prog_n", 32'(o_ram_prog_n), 32'd1);
            checkOutput("abort_cpu_hold", 32'(o_cpu_hold), 32'd0);
            checkOutput("abort_busy", 32'(o_busy), 32'd0);
            repeat (4) @(negedge i_clk);
            checkOutput("abort_no_done", 32'(doneTotal - doneBase), 32'd0);
        end else begin
            for (int t = 0; t < 60; t++) begin
                @(negedge i_clk);
                if (o_done === 1'b1) begin
                    got = 1;
                    break;
                end
            end
            if (!got) checkOutput("done_timeout", 32'd0, 32'd1);
            checkOutput("finish_wr_prog", 32'(o_wr_prog), 32'd0);
            checkOutput("finish_ram_prog_n", 32'(o_ram_prog_n), 32'd0);
            @(negedge i_clk);
            checkOutput("after_done_busy", 32'(o_busy), 32'd0);
            checkOutput("after_done_ram_prog_n", 32'(o_ram_prog_n), 32'd1);
            checkOutput("after_done_done", 32'(o_done), 32'd0);
            checkOutput("done_count", 32'(doneTotal - doneBase), 32'd1);
        end
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        checkImage();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_last_addr  = 4'd0;
        i_fill_en    = 1'b0;
        i_abort      = 1'b0;
        i_data_in    = 8'h00;
        i_data_valid = 1'b0;
        #2;
        checkResetOutputs();
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;

        // Basic load, VALID held high, no fill.
        $display("[TB] session: 4 bytes, no fill");
        sessBytes[0] = 8'h1A; sessBytes[1] = 8'h2B; sessBytes[2] = 8'h3C; sessBytes[3] = 8'h4D;
        for (int i = 0; i < 16; i++) sessGaps[i] = 0;
        applyStimulus(3, 1'b0, -1, 1'b0);
        checkOutput("t1_write_count", 32'(writeCycles.size() - lastWcBase), 32'd4);
        for (int i = 1; i < 4; i++)
            checkOutput("t1_spacing", 32'(writeCycles[lastWcBase + i] - writeCycles[lastWcBase + i - 1]), 32'd2);

        // Two bytes then zero fill of addresses 2..15.
        $display("[TB] session: 2 bytes plus fill");
        sessBytes[0] = 8'hE0; sessBytes[1] = 8'hF1;
        applyStimulus(1, 1'b1, -1, 1'b0);
        checkOutput("t2_write_count", 32'(writeCycles.size() - lastWcBase), 32'd16);
        for (int i = 2; i < 16; i++)
            checkOutput("t2_fill_spacing", 32'(writeCycles[lastWcBase + i] - writeCycles[lastWcBase + i - 1]), 32'd1);

        // Valid gaps of 0..5 cycles between bytes.
        $display("[TB] session: valid gaps");
        for (int i = 0; i < 6; i++) begin
            sessBytes[i] = 8'(8'h11 * (i + 1));
            sessGaps[i]  = i;
        end
        applyStimulus(5, 1'b0, -1, 1'b0);
        checkOutput("t3_write_count", 32'(writeCycles.size() - lastWcBase), 32'd6);

        // Full 16-byte load with fill requested, plus a START pulse mid-session.
        $display("[TB] session: 16 bytes, fill skipped, mid-session start");
        for (int i = 0; i < 16; i++) begin
            sessBytes[i] = 8'(8'hA0 + i * 3);
            sessGaps[i]  = 0;
        end
        applyStimulus(15, 1'b1, -1, 1'b1);
        checkOutput("t6_write_count", 32'(writeCycles.size() - lastWcBase), 32'd16);

        // Abort while filling address 7.
        $display("[TB] session: abort during fill");
        sessBytes[0] = 8'h5A; sessBytes[1] = 8'h6B; sessBytes[2] = 8'h7C;
        applyStimulus(2, 1'b1, 7, 1'b0);

        // Asynchronous reset in the middle of LOAD, START held during reset.
        $display("[TB] session: reset mid-load");
        expQ.push_back({4'd0, 8'h77});
        expImage[0] = 8'h77;
        @(posedge i_clk);
        #1;
        i_start      = 1'b1;
        i_last_addr  = 4'd3;
        i_fill_en    = 1'b0;
        i_data_valid = 1'b0;
        @(posedge i_clk);
        #1;
        i_start      = 1'b0;
        i_data_valid = 1'b1;
        i_data_in    = 8'h77;
        @(posedge i_clk);
        #1;
        i_data_valid = 1'b0;
        @(posedge i_clk);
        #2;
        checkOutput("t5_in_load_ready", 32'(o_data_ready), 32'd1);
        i_rst   = 1'b1;
        i_start = 1'b1;
        #1;
        checkResetOutputs();
        @(negedge i_clk);
        @(negedge i_clk);
        checkOutput("t5_start_in_reset_busy", 32'(o_busy), 32'd0);
        i_start = 1'b0;
        i_rst   = 1'b0;
        @(negedge i_clk);
        checkOutput("t5_idle_after_reset", 32'(o_busy), 32'd0);
        checkOutput("t5_queue_after_reset", 32'(expQ.size()), 32'd0);

        $display("[TB] session: recovery after reset");
        sessBytes[0] = 8'hC1; sessBytes[1] = 8'hC2; sessBytes[2] = 8'hC3;
        for (int i = 0; i < 16; i++) sessGaps[i] = 0;
        applyStimulus(2, 1'b0, -1, 1'b0);

        repeat (3) @(negedge i_clk);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
